obi_uart: RTL
=============

Name: obi_uart

Overview:
- OBI-style responder UART peripheral for the cv32e40x data bus. It is the slave end of the core's req/gnt/rvalid protocol.
- Replaces the always-grant UART glue with a proper responder. Stalls via gnt when TX is full; returns registered rdata/err with rvalid.
- Contains a TX holding register plus shifter, an RX deserializer, and an RX FIFO.
- Mapped at SoC base 0x200000. The interconnect decodes the base; the block sees only local offset bits.

Parameters:
- CLK_FREQ, 25_000_000, clock frequency in Hz.
- BAUDRATE, 115200, reset baud rate. Reset divider is CLK_FREQ/BAUDRATE = 217.
- RX_FIFO_DEPTH, 8, RX FIFO entries. Must be a power of 2, minimum 2.
- DIV_WIDTH, 16, width of the divider register.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  OBI request (already qualified by address decode).
- gnt_o  out  1  OBI grant, combinational.
- addr_i  in  4  local byte offset; bits [1:0] ignored.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- err_o  out  1  error response, valid with rvalid_o.
- ser_tx_o  out  1  serial out, idles high.
- ser_rx_i  in  1  serial in, asynchronous.
- irq_o  out  1  high while the RX FIFO is non-empty.

Behaviour:
- Reset values: rvalid_o=0, rdata_o=0, err_o=0, ser_tx_o=1, irq_o=0, DIV=CLK_FREQ/BAUDRATE. FIFO, holding register and all sticky flags are cleared.
- Reset mid-frame aborts TX/RX immediately. The line returns high.
- Register map:
  - 0x0 DATA. Write with be_i[0] loads wdata_i[7:0] into the TX holding register. Read pops the RX FIFO and returns {24'b0, byte}; an empty FIFO returns 0xFFFF_FFFF with no pop.
  - 0x4 STATUS, read-only. Bit0 tx_busy (holding full or shifter active). Bit1 rx_valid. Bit2 rx_full. Bit3 rx_overrun (sticky). Bit4 frame_err (sticky). A STATUS read returns the current value, then clears bits 3 and 4.
  - 0x8 DIV, read/write. Bits [DIV_WIDTH-1:0]. Writes with value <4 are ignored. Byte enables apply per byte.
  - 0xC: unmapped. Response has err_o=1, rdata_o=0, no side effects. Writes to STATUS also give err_o=1.
- Handshake:
  - gnt_o = req_i, except gnt_o=0 when we_i=1, addr=DATA, and the holding register is full.
  - A transaction is accepted when req_i & gnt_o. rvalid_o is asserted exactly one cycle after acceptance. rdata_o/err_o are registered in the same cycle.
  - Back-to-back accepted requests give back-to-back rvalid. The responder has no backpressure on rvalid.
  - Writes respond with rdata_o=0.
- TX:
  - FSM IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE. Each bit lasts DIV cycles.
  - In IDLE with the holding register full: load the shifter and clear the holding register in the same cycle.
  - If a write and a load coincide, the write is accepted (holding empty or being drained) and is granted.
  - tx_busy goes 0 at the end of STOP when the holding register is empty.
- RX:
  - Input passes through a 2-FF synchronizer.
  - FSM: IDLE -> START on synchronized low. START waits DIV/2 cycles and resamples; high means a false start and returns to IDLE.
  - DATA samples 8 bits at DIV intervals. STOP samples after DIV.
  - Stop bit 1: push the byte. If the FIFO is full and there is no simultaneous pop, drop the byte and set rx_overrun.
  - Stop bit 0: set frame_err, no push, stay in WAIT_IDLE until the line is high.
- FIFO:
  - Simultaneous push and pop leaves the count unchanged; push succeeds even when full.
  - Pointers are log2(DEPTH) bits wide, with an explicit count of log2(DEPTH)+1 bits. Wrap-around is natural.
- DIV: changes take effect at the next bit-period reload. Frames in flight keep the current count.
- Bit counters are 3 bits; baud counters are DIV_WIDTH bits and count down to 1.

Decomposition:
- Package obi_uart_pkg:
  - Register offset localparams (REG_DATA, REG_STATUS, REG_DIV).
  - STATUS bit indices.
  - tx_state_e {TX_IDLE, TX_START, TX_DATA, TX_STOP}.
  - rx_state_e {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE}.
- Sub-module obi_uart_rx_fifo: synchronous FIFO with push/pop/full/empty/count. Parameterized by depth and width 8.

Test Plan:
- Reset, then read 0x8 -> rvalid one cycle after gnt, rdata=217, err=0. ser_tx_o=1 throughout.
- Write DIV=4, then write DATA=0x55 -> ser_tx_o shows 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit. STATUS bit0=1 during the frame and 0 after 40 cycles.
- Three back-to-back DATA writes 0xA5, 0x3C, 0x0F -> the first two are granted immediately. The third sees gnt_o=0 until 0x3C loads into the shifter. The line carries A5, 3C, 0F in order.
- Drive a ser_rx_i frame of 0xC3 at DIV=4 -> irq_o=1, STATUS=0x2. DATA read returns 0x000000C3, then STATUS bit1=0 and irq_o=0. A DATA read while empty returns 0xFFFFFFFF.
- Send 9 frames 0x01..0x09 without reading -> STATUS=0x0E (busy clear, valid, full, overrun). Reads return 0x01..0x08. A second STATUS read shows bit3=0.
- Inject a 1-cycle low glitch -> no push. Send a frame with stop=0 -> STATUS bit4=1, no push. Read 0xC -> err_o=1, rdata 0. Assert rst_ni mid-TX -> ser_tx_o=1 immediately.

Source files
------------

// File: rtl/obi_uart_pkg.sv
// Shared register map, STATUS bit positions and FSM state encodings for the OBI UART.
package obi_uart_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_DIV    = 4'h8;

    localparam int unsigned STAT_TX_BUSY    = 0;
    localparam int unsigned STAT_RX_VALID   = 1;
    localparam int unsigned STAT_RX_FULL    = 2;
    localparam int unsigned STAT_RX_OVERRUN = 3;
    localparam int unsigned STAT_FRAME_ERR  = 4;
    localparam int unsigned STAT_WIDTH      = 5;

    typedef logic [1:0] tx_state_e;
    localparam tx_state_e TX_IDLE  = 2'd0;
    localparam tx_state_e TX_START = 2'd1;
    localparam tx_state_e TX_DATA  = 2'd2;
    localparam tx_state_e TX_STOP  = 2'd3;

    typedef logic [2:0] rx_state_e;
    localparam rx_state_e RX_IDLE      = 3'd0;
    localparam rx_state_e RX_START     = 3'd1;
    localparam rx_state_e RX_DATA      = 3'd2;
    localparam rx_state_e RX_STOP      = 3'd3;
    localparam rx_state_e RX_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/obi_uart_rx_fifo.sv
// Synchronous FIFO for received bytes; a push into a full FIFO only lands when a pop coincides.
module obi_uart_rx_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_uart.sv
// OBI responder UART: TX holding register + shifter, RX deserializer feeding an RX FIFO,
// registered single-cycle responses with grant stalling while the TX holding register is full.
module obi_uart #(
    parameter int unsigned CLK_FREQ      = 25_000_000,
    parameter int unsigned BAUDRATE      = 115200,
    parameter int unsigned RX_FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH     = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [3:0]  addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        ser_tx_o,
    input  logic        ser_rx_i,
    output logic        irq_o
);

    import obi_uart_pkg::*;

    localparam logic [DIV_WIDTH-1:0] DivReset = DIV_WIDTH'(CLK_FREQ / BAUDRATE);
    localparam logic [DIV_WIDTH-1:0] CntOne   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DivMin   = DIV_WIDTH'(4);

    // Bus decode and handshake
    logic [3:0] reg_off;
    logic       sel_data, sel_status, sel_div;
    logic       accept, tx_load;
    logic       wr_data, rd_data, rd_status, wr_div;

    // Registers
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [7:0]           hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rvalid_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [31:0]          div_merge;
    logic [STAT_WIDTH-1:0] status;

    // TX
    tx_state_e            tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [7:0]           tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d;
    logic                 tx_last;

    // RX
    logic                 rx_meta_q, rx_sync_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic                 rx_last, rx_push, rx_frame_set, rx_overrun_set;

    // FIFO
    logic                       fifo_pop, fifo_full, fifo_empty;
    logic [7:0]                 fifo_rdata;
    logic [$clog2(RX_FIFO_DEPTH):0] fifo_count;
    logic                       unused_sink;

    assign reg_off    = {addr_i[3:2], 2'b00};
    assign sel_data   = (reg_off == REG_DATA);
    assign sel_status = (reg_off == REG_STATUS);
    assign sel_div    = (reg_off == REG_DIV);

    assign tx_load = (tx_state_q == TX_IDLE) & hold_full_q;
    // A write landing in the same cycle the holding register drains into the shifter is granted.
    assign gnt_o   = req_i & ~(we_i & sel_data & hold_full_q & ~tx_load);
    assign accept  = req_i & gnt_o;

    assign wr_data   = accept & we_i & sel_data & be_i[0];
    assign rd_data   = accept & ~we_i & sel_data;
    assign rd_status = accept & ~we_i & sel_status;
    assign wr_div    = accept & we_i & sel_div;
    assign fifo_pop  = rd_data & ~fifo_empty;

    always_comb begin
        status                  = '0;
        status[STAT_TX_BUSY]    = hold_full_q | (tx_state_q != TX_IDLE);
        status[STAT_RX_VALID]   = ~fifo_empty;
        status[STAT_RX_FULL]    = fifo_full;
        status[STAT_RX_OVERRUN] = overrun_q;
        status[STAT_FRAME_ERR]  = frame_err_q;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            div_merge[8*i +: 8] = be_i[i] ? wdata_i[8*i +: 8] : 8'(32'(div_q) >> (8 * i));
        end
    end

    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (accept) begin
            case (reg_off)
                REG_DATA: begin
                    if (!we_i) begin
                        rdata_d = fifo_empty ? 32'hFFFF_FFFF : {24'b0, fifo_rdata};
                    end
                end
                REG_STATUS: begin
                    if (we_i) begin
                        err_d = 1'b1;
                    end else begin
                        rdata_d = 32'(status);
                    end
                end
                REG_DIV: begin
                    if (!we_i) begin
                        rdata_d = 32'(div_q);
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        div_d       = div_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (wr_div && (div_merge[DIV_WIDTH-1:0] >= DivMin)) begin
            div_d = div_merge[DIV_WIDTH-1:0];
        end
        if (tx_load) begin
            hold_full_d = 1'b0;
        end
        if (wr_data) begin
            hold_full_d = 1'b1;
            hold_d      = wdata_i[7:0];
        end
        // Clear-on-read first so an event in the same cycle is not lost.
        if (rd_status) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_overrun_set) begin
            overrun_d = 1'b1;
        end
        if (rx_frame_set) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q       <= DivReset;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rvalid_q    <= accept;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    assign tx_last = (tx_cnt_q == CntOne);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    tx_state_d = TX_START;
                    tx_shift_d = hold_q;
                    tx_cnt_d   = div_q;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_last) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = div_q;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - CntOne;
                end
            end
            TX_DATA: begin
                if (tx_last) begin
                    tx_cnt_d = div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CntOne;
                end
            end
            TX_STOP: begin
                if (tx_last) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - CntOne;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    assign ser_tx_o = tx_q;

    assign rx_last = (rx_cnt_q == CntOne);

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_push      = 1'b0;
        rx_frame_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = div_q >> 1;
                end
            end
            RX_START: begin
                if (rx_last) begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = div_q;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CntOne;
                end
            end
            RX_DATA: begin
                if (rx_last) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = div_q;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CntOne;
                end
            end
            RX_STOP: begin
                if (rx_last) begin
                    if (rx_sync_q) begin
                        rx_push    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_frame_set = 1'b1;
                        rx_state_d   = RX_WAIT_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CntOne;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_overrun_set = rx_push & fifo_full & ~fifo_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= ser_rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    obi_uart_rx_fifo #(
        .Depth (RX_FIFO_DEPTH),
        .Width (8)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rx_push),
        .wdata_i (rx_shift_q),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign irq_o = ~fifo_empty;

    assign unused_sink = ^{addr_i[1:0], fifo_count, div_merge};

endmodule
